// File: rtl/cpu_cache_controller_if.sv
// Shared-bus side of the CPU cache controller: arbitration, word transfers and acknowledge.
// The controller is the master; the bus/arbiter side is the slave.
interface cpu_cache_controller_if #(
   parameter int ADDRESS_WIDTH = 14,
   parameter int DATA_WIDTH    = 16
);
   logic                     bus_request;
   logic                     bus_grant;
   logic [ADDRESS_WIDTH-1:0] bus_address;
   logic                     bus_read;
   logic                     bus_read_exclusive;
   logic                     bus_invalidate;
   logic                     bus_writeback;
   logic [DATA_WIDTH-1:0]    bus_data_out;
   logic [DATA_WIDTH-1:0]    bus_data_in;
   logic                     bus_ack;

   modport master (
      output bus_request,
      output bus_address,
      output bus_read,
      output bus_read_exclusive,
      output bus_invalidate,
      output bus_writeback,
      output bus_data_out,
      input  bus_grant,
      input  bus_data_in,
      input  bus_ack
   );

   modport slave (
      input  bus_request,
      input  bus_address,
      input  bus_read,
      input  bus_read_exclusive,
      input  bus_invalidate,
      input  bus_writeback,
      input  bus_data_out,
      output bus_grant,
      output bus_data_in,
      output bus_ack
   );
endinterface

// File: rtl/cpu_cache_controller.sv
// CPU-side MSI controller for a direct-mapped snoopy cache: serves hits with zero wait states,
// and on a miss or write upgrade arbitrates for the bus, writes back a dirty victim and refills.
module cpu_cache_controller #(
   parameter int TAG_WIDTH     = 8,
   parameter int INDEX_WIDTH   = 4,
   parameter int OFFSET_WIDTH  = 2,
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] cpu_address,
   input  logic                     cpu_read,
   input  logic                     cpu_write,
   input  logic [DATA_WIDTH-1:0]    cpu_data_in,
   output logic [DATA_WIDTH-1:0]    cpu_data_out,
   output logic                     cpu_complete,
   output logic [INDEX_WIDTH-1:0]   array_index,
   output logic [OFFSET_WIDTH-1:0]  array_offset,
   output logic [TAG_WIDTH-1:0]     array_tag,
   input  logic [TAG_WIDTH-1:0]     array_tag_read,
   input  logic [1:0]               array_state_read,
   input  logic                     array_hit,
   input  logic [DATA_WIDTH-1:0]    array_data_read,
   output logic                     array_write_tag,
   output logic                     array_write_state,
   output logic [1:0]               array_state,
   output logic                     array_write_data,
   output logic [DATA_WIDTH-1:0]    array_data,
   cpu_cache_controller_if.master   bus
);

   localparam logic [1:0] MSI_INVALID  = 2'b00;
   localparam logic [1:0] MSI_SHARED   = 2'b01;
   localparam logic [1:0] MSI_MODIFIED = 2'b10;

   localparam logic [OFFSET_WIDTH-1:0] WORD_ZERO = {OFFSET_WIDTH{1'b0}};
   localparam logic [OFFSET_WIDTH-1:0] WORD_ONE  = OFFSET_WIDTH'(1);
   localparam logic [OFFSET_WIDTH-1:0] WORD_LAST = {OFFSET_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARBITRATE = 3'd1,
      UPGRADE   = 3'd2,
      WRITEBACK = 3'd3,
      FILL      = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [OFFSET_WIDTH-1:0] counter_q, counter_d;
   logic [TAG_WIDTH-1:0]    req_tag_q, req_tag_d;
   logic [INDEX_WIDTH-1:0]  req_index_q, req_index_d;
   logic                    req_write_q, req_write_d;
   logic                    upgrade_q, upgrade_d;

   logic [TAG_WIDTH-1:0]     cpu_tag_s;
   logic [INDEX_WIDTH-1:0]   cpu_index_s;
   logic [OFFSET_WIDTH-1:0]  cpu_offset_s;

   logic [DATA_WIDTH-1:0]    cpu_data_out_s;
   logic                     cpu_complete_s;
   logic                     array_write_tag_s;
   logic                     array_write_state_s;
   logic [1:0]               array_state_s;
   logic                     array_write_data_s;
   logic [DATA_WIDTH-1:0]    array_data_s;
   logic                     bus_request_s;
   logic [ADDRESS_WIDTH-1:0] bus_address_s;
   logic                     bus_read_s;
   logic                     bus_read_exclusive_s;
   logic                     bus_invalidate_s;
   logic                     bus_writeback_s;
   logic [DATA_WIDTH-1:0]    bus_data_out_s;

   assign cpu_tag_s    = cpu_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
   assign cpu_index_s  = cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
   assign cpu_offset_s = cpu_address[OFFSET_WIDTH-1:0];

   // State, word counter and latched request registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         counter_q   <= WORD_ZERO;
         req_tag_q   <= {TAG_WIDTH{1'b0}};
         req_index_q <= {INDEX_WIDTH{1'b0}};
         req_write_q <= 1'b0;
         upgrade_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         req_tag_q   <= req_tag_d;
         req_index_q <= req_index_d;
         req_write_q <= req_write_d;
         upgrade_q   <= upgrade_d;
      end
   end

   // Next-state logic and raw array/bus/CPU controls
   always_comb begin
      state_d              = state_q;
      counter_d            = counter_q;
      req_tag_d            = req_tag_q;
      req_index_d          = req_index_q;
      req_write_d          = req_write_q;
      upgrade_d            = upgrade_q;
      array_index          = req_index_q;
      array_tag            = req_tag_q;
      array_offset         = counter_q;
      cpu_data_out_s       = {DATA_WIDTH{1'b0}};
      cpu_complete_s       = 1'b0;
      array_write_tag_s    = 1'b0;
      array_write_state_s  = 1'b0;
      array_state_s        = MSI_INVALID;
      array_write_data_s   = 1'b0;
      array_data_s         = {DATA_WIDTH{1'b0}};
      bus_request_s        = 1'b0;
      bus_address_s        = {req_tag_q, req_index_q, counter_q};
      bus_read_s           = 1'b0;
      bus_read_exclusive_s = 1'b0;
      bus_invalidate_s     = 1'b0;
      bus_writeback_s      = 1'b0;
      bus_data_out_s       = {DATA_WIDTH{1'b0}};

      case (state_q)
         IDLE: begin
            array_index  = cpu_index_s;
            array_tag    = cpu_tag_s;
            array_offset = cpu_offset_s;
            counter_d    = WORD_ZERO;
            if (cpu_read && array_hit) begin
               cpu_complete_s = 1'b1;
               cpu_data_out_s = array_data_read;
            end else if (cpu_write && !cpu_read && array_hit && (array_state_read == MSI_MODIFIED)) begin
               array_write_data_s = 1'b1;
               array_data_s       = cpu_data_in;
               cpu_complete_s     = 1'b1;
            end else if (cpu_read || cpu_write) begin
               // Miss, or a write to a SHARED line that must first upgrade to MODIFIED
               req_tag_d   = cpu_tag_s;
               req_index_d = cpu_index_s;
               req_write_d = !cpu_read;
               upgrade_d   = !cpu_read && array_hit && (array_state_read == MSI_SHARED);
               state_d     = ARBITRATE;
            end else begin
               state_d = IDLE;
            end
         end

         ARBITRATE: begin
            bus_request_s = 1'b1;
            counter_d     = WORD_ZERO;
            if (!bus.bus_grant) begin
               state_d = ARBITRATE;
            end else if (upgrade_q) begin
               state_d = UPGRADE;
            end else if (array_state_read == MSI_MODIFIED) begin
               state_d = WRITEBACK;
            end else begin
               state_d = FILL;
            end
         end

         UPGRADE: begin
            bus_request_s    = 1'b1;
            bus_invalidate_s = 1'b1;
            bus_address_s    = {req_tag_q, req_index_q, WORD_ZERO};
            if (bus.bus_ack) begin
               // A line snooped away meanwhile is left invalid so IDLE sees a plain miss
               array_write_state_s = array_hit;
               array_state_s       = MSI_MODIFIED;
               upgrade_d           = 1'b0;
               state_d             = IDLE;
            end else begin
               state_d = UPGRADE;
            end
         end

         WRITEBACK: begin
            bus_request_s   = 1'b1;
            bus_writeback_s = 1'b1;
            bus_address_s   = {array_tag_read, req_index_q, counter_q};
            bus_data_out_s  = array_data_read;
            if (bus.bus_ack) begin
               counter_d = counter_q + WORD_ONE;
               state_d   = (counter_q == WORD_LAST) ? FILL : WRITEBACK;
            end else begin
               state_d = WRITEBACK;
            end
         end

         FILL: begin
            bus_request_s        = 1'b1;
            bus_read_s           = !req_write_q;
            bus_read_exclusive_s = req_write_q;
            if (bus.bus_ack) begin
               array_write_data_s = 1'b1;
               array_data_s       = bus.bus_data_in;
               counter_d          = counter_q + WORD_ONE;
               if (counter_q == WORD_LAST) begin
                  array_write_tag_s   = 1'b1;
                  array_write_state_s = 1'b1;
                  array_state_s       = req_write_q ? MSI_MODIFIED : MSI_SHARED;
                  state_d             = IDLE;
               end else begin
                  state_d = FILL;
               end
            end else begin
               state_d = FILL;
            end
         end

         default: begin
            state_d   = IDLE;
            counter_d = WORD_ZERO;
         end
      endcase
   end

   // Reset forces every strobe, bus control and data output low
   always_comb begin
      if (reset) begin
         cpu_data_out           = {DATA_WIDTH{1'b0}};
         cpu_complete           = 1'b0;
         array_write_tag        = 1'b0;
         array_write_state      = 1'b0;
         array_state            = MSI_INVALID;
         array_write_data       = 1'b0;
         array_data             = {DATA_WIDTH{1'b0}};
         bus.bus_request        = 1'b0;
         bus.bus_address        = {ADDRESS_WIDTH{1'b0}};
         bus.bus_read           = 1'b0;
         bus.bus_read_exclusive = 1'b0;
         bus.bus_invalidate     = 1'b0;
         bus.bus_writeback      = 1'b0;
         bus.bus_data_out       = {DATA_WIDTH{1'b0}};
      end else begin
         cpu_data_out           = cpu_data_out_s;
         cpu_complete           = cpu_complete_s;
         array_write_tag        = array_write_tag_s;
         array_write_state      = array_write_state_s;
         array_state            = array_state_s;
         array_write_data       = array_write_data_s;
         array_data             = array_data_s;
         bus.bus_request        = bus_request_s;
         bus.bus_address        = bus_address_s;
         bus.bus_read           = bus_read_s;
         bus.bus_read_exclusive = bus_read_exclusive_s;
         bus.bus_invalidate     = bus_invalidate_s;
         bus.bus_writeback      = bus_writeback_s;
         bus.bus_data_out       = bus_data_out_s;
      end
   end

endmodule

// File: tb/tb_cpu_cache_controller.sv
// Directed bench: models the line store and the bus/arbiter, checks bus words and completions
// against queues of expected results filled as each request is issued.
module tb_cpu_cache_controller;

   localparam logic [3:0] OP_RD  = 4'b1000;
   localparam logic [3:0] OP_RDX = 4'b0100;
   localparam logic [3:0] OP_WB  = 4'b0010;
   localparam logic [3:0] OP_INV = 4'b0001;

   typedef struct packed {
      logic [3:0]  op;
      logic [13:0] addr;
      logic [15:0] data;
   } bus_txn_t;

   typedef struct packed {
      logic        is_read;
      logic [15:0] data;
   } cpl_t;

   logic        clock;
   logic        reset;
   logic [13:0] cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [15:0] cpu_data_in;
   logic [15:0] cpu_data_out;
   logic        cpu_complete;
   logic [3:0]  array_index;
   logic [1:0]  array_offset;
   logic [7:0]  array_tag;
   logic [7:0]  array_tag_read;
   logic [1:0]  array_state_read;
   logic        array_hit;
   logic [15:0] array_data_read;
   logic        array_write_tag;
   logic        array_write_state;
   logic [1:0]  array_state;
   logic        array_write_data;
   logic [15:0] array_data;

   cpu_cache_controller_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(16)) bus_if ();

   cpu_cache_controller dut (
      .clock             (clock),
      .reset             (reset),
      .cpu_address       (cpu_address),
      .cpu_read          (cpu_read),
      .cpu_write         (cpu_write),
      .cpu_data_in       (cpu_data_in),
      .cpu_data_out      (cpu_data_out),
      .cpu_complete      (cpu_complete),
      .array_index       (array_index),
      .array_offset      (array_offset),
      .array_tag         (array_tag),
      .array_tag_read    (array_tag_read),
      .array_state_read  (array_state_read),
      .array_hit         (array_hit),
      .array_data_read   (array_data_read),
      .array_write_tag   (array_write_tag),
      .array_write_state (array_write_state),
      .array_state       (array_state),
      .array_write_data  (array_write_data),
      .array_data        (array_data),
      .bus               (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Line store model
   logic [7:0]  tag_mem   [16];
   logic [1:0]  state_mem [16];
   logic [15:0] data_mem  [16][4];
   logic        pl_en;
   logic [3:0]  pl_idx;
   logic [7:0]  pl_tag;
   logic [1:0]  pl_state;
   logic [1:0]  pl_off;
   logic [15:0] pl_data;

   assign array_tag_read   = tag_mem[array_index];
   assign array_state_read = state_mem[array_index];
   assign array_data_read  = data_mem[array_index][array_offset];
   assign array_hit        = (tag_mem[array_index] == array_tag) && (state_mem[array_index] != 2'b00);

   always @(posedge clock) begin
      if (pl_en) begin
         tag_mem[pl_idx]           <= pl_tag;
         state_mem[pl_idx]         <= pl_state;
         data_mem[pl_idx][pl_off]  <= pl_data;
      end else begin
         if (array_write_tag)   tag_mem[array_index] <= array_tag;
         if (array_write_state) state_mem[array_index] <= array_state;
         if (array_write_data)  data_mem[array_index][array_offset] <= array_data;
      end
   end

   bus_txn_t bus_q[$];
   cpl_t     cpl_q[$];
   int       n_cmp = 0;
   int       n_err = 0;
   int       grant_delay = 0;
   int       wait_cnt = 0;
   int       acks = 0;
   int       req_rises = 0;
   logic     prev_req = 1'b0;
   logic     got_cpl = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] mk(input logic [7:0] t, input logic [3:0] i, input logic [1:0] o);
      return {t, i, o};
   endfunction

   task automatic push_line(input logic [3:0] op, input logic [7:0] t, input logic [3:0] i, input logic [15:0] base);
      for (int k = 0; k < 4; k++) begin
         bus_q.push_back('{op: op, addr: mk(t, i, 2'(k)), data: base + 16'(k)});
      end
   endtask

   task automatic preload(input logic [3:0] i, input logic [7:0] t, input logic [1:0] s,
                          input logic [1:0] o, input logic [15:0] d);
      pl_en = 1'b1; pl_idx = i; pl_tag = t; pl_state = s; pl_off = o; pl_data = d;
      @(negedge clock);
      pl_en = 1'b0;
   endtask

   // One cycle, entered at a negedge: sample, act as arbiter/bus slave, score outputs
   task automatic tick();
      bus_txn_t   t;
      cpl_t       c;
      logic [3:0] op;
      #1;
      if (cpu_complete === 1'b1) begin
         got_cpl = 1'b1;
         if (cpl_q.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
         end else begin
            c = cpl_q.pop_front();
            if (c.is_read) check("cpu_data_out", cpu_data_out, c.data);
         end
      end
      if (bus_if.bus_request === 1'b1 && !prev_req) req_rises++;
      prev_req = bus_if.bus_request;
      if (bus_if.bus_request === 1'b1) begin
         if (wait_cnt >= grant_delay) bus_if.bus_grant = 1'b1;
         else wait_cnt++;
      end else begin
         bus_if.bus_grant = 1'b0;
         wait_cnt = 0;
      end
      op = {bus_if.bus_read, bus_if.bus_read_exclusive, bus_if.bus_writeback, bus_if.bus_invalidate};
      if (op != 4'b0000) begin
         if (bus_q.size() == 0) begin
            check("unexpected_bus_op", op, 32'd0);
         end else begin
            t = bus_q.pop_front();
            check("bus_op", op, t.op);
            if (t.op == OP_INV) check("bus_line", bus_if.bus_address[13:2], t.addr[13:2]);
            else check("bus_address", bus_if.bus_address, t.addr);
            if (t.op == OP_WB) check("bus_data_out", bus_if.bus_data_out, t.data);
            bus_if.bus_data_in = t.data;
            bus_if.bus_ack = 1'b1;
            acks++;
            #1;
            if (t.op == OP_RD || t.op == OP_RDX)
               check("fill_write", {array_write_data, array_data}, {1'b1, t.data});
            if (t.op == OP_INV)
               check("upgrade_state_write", {array_write_state, array_state}, {1'b1, 2'b10});
         end
      end
      @(negedge clock);
      bus_if.bus_ack = 1'b0;
   endtask

   task automatic run_req(input logic rd, input logic wr, input logic [13:0] addr, input logic [15:0] wd,
                          input int gdel, input int exp_lat, input int exp_rises);
      int n;
      cpu_address = addr; cpu_read = rd; cpu_write = wr; cpu_data_in = wd;
      grant_delay = gdel; got_cpl = 1'b0; req_rises = 0; prev_req = 1'b0; n = 0;
      while (!got_cpl && n < 300) begin
         tick();
         if (!got_cpl) n++;
      end
      cpu_read = 1'b0; cpu_write = 1'b0;
      check("latency", n, exp_lat);
      check("bus_request_rises", req_rises, exp_rises);
      check("queues_drained", bus_q.size() + cpl_q.size(), 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b1; cpu_address = 14'd0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_data_in = 16'd0;
      pl_en = 1'b0; pl_idx = 4'd0; pl_tag = 8'd0; pl_state = 2'b00; pl_off = 2'd0; pl_data = 16'd0;
      bus_if.bus_grant = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_data_in = 16'd0;
      @(negedge clock);
      for (int i = 0; i < 16; i++) preload(4'(i), 8'h00, 2'b00, 2'd0, 16'h0000);
      preload(4'd3, 8'h12, 2'b01, 2'd1, 16'hBEEF);
      preload(4'd2, 8'h33, 2'b01, 2'd3, 16'h0000);

      // Reset holds everything low even with a hitting read presented
      cpu_address = mk(8'h12, 4'd3, 2'd1); cpu_read = 1'b1;
      #1;
      check("reset_outputs", {bus_if.bus_request, cpu_complete, array_write_tag, array_write_state,
                              array_write_data, bus_if.bus_read, bus_if.bus_writeback}, 32'd0);
      check("reset_data", {cpu_data_out, bus_if.bus_data_out}, 32'd0);
      @(negedge clock);
      reset = 1'b0; cpu_read = 1'b0;
      #1;
      check("idle_after_reset", {bus_if.bus_request, cpu_complete}, 32'd0);
      @(negedge clock);

      // Read hit, zero wait states
      cpl_q.push_back('{is_read: 1'b1, data: 16'hBEEF});
      run_req(1'b1, 1'b0, mk(8'h12, 4'd3, 2'd1), 16'h0000, 0, 0, 0);

      // Read miss with clean victim
      push_line(OP_RD, 8'h40, 4'd5, 16'h00A0);
      cpl_q.push_back('{is_read: 1'b1, data: 16'h00A2});
      run_req(1'b1, 1'b0, mk(8'h40, 4'd5, 2'd2), 16'h0000, 0, 6, 1);
      check("miss_tag", tag_mem[5], 32'h40);
      check("miss_state", state_mem[5], 32'h1);

      // Dirty eviction on a write miss
      preload(4'd5, 8'h40, 2'b10, 2'd0, 16'h00A0);
      push_line(OP_WB, 8'h40, 4'd5, 16'h00A0);
      push_line(OP_RDX, 8'h41, 4'd5, 16'h00B0);
      cpl_q.push_back('{is_read: 1'b0, data: 16'h0000});
      run_req(1'b0, 1'b1, mk(8'h41, 4'd5, 2'd1), 16'h1234, 2, 12, 1);
      check("evict_tag", tag_mem[5], 32'h41);
      check("evict_state", state_mem[5], 32'h2);
      check("evict_cpu_word", data_mem[5][1], 32'h1234);
      check("evict_fill_word", data_mem[5][3], 32'h00B3);

      // Upgrade of a SHARED hit
      bus_q.push_back('{op: OP_INV, addr: mk(8'h33, 4'd2, 2'd3), data: 16'h0000});
      cpl_q.push_back('{is_read: 1'b0, data: 16'h0000});
      run_req(1'b0, 1'b1, mk(8'h33, 4'd2, 2'd3), 16'h5555, 0, 3, 1);
      check("upgrade_state", state_mem[2], 32'h2);
      check("upgrade_word", data_mem[2][3], 32'h5555);

      // Write hit on a MODIFIED line
      cpl_q.push_back('{is_read: 1'b0, data: 16'h0000});
      run_req(1'b0, 1'b1, mk(8'h33, 4'd2, 2'd0), 16'h7777, 0, 0, 0);
      check("write_hit_word", data_mem[2][0], 32'h7777);

      // Read wins when both strobes are high
      cpl_q.push_back('{is_read: 1'b1, data: 16'h5555});
      run_req(1'b1, 1'b1, mk(8'h33, 4'd2, 2'd3), 16'hDEAD, 0, 0, 0);
      check("read_priority_word", data_mem[2][3], 32'h5555);

      // Stray ack in IDLE is ignored
      bus_if.bus_ack = 1'b1; bus_if.bus_data_in = 16'hFFFF;
      #1;
      check("stray_ack", {bus_if.bus_request, array_write_data, array_write_tag, array_write_state, cpu_complete}, 32'd0);
      @(negedge clock);
      bus_if.bus_ack = 1'b0;
      #1;
      check("stray_ack_after", bus_if.bus_request, 32'd0);
      @(negedge clock);

      // Delayed grant, reset after the second fill word
      push_line(OP_RD, 8'h77, 4'd6, 16'h00C0);
      cpu_address = mk(8'h77, 4'd6, 2'd0); cpu_read = 1'b1;
      grant_delay = 7; acks = 0; n = 0;
      while (acks < 2 && n < 100) begin
         tick();
         n++;
      end
      check("grant_wait_cycles", n, 32'd11);
      reset = 1'b1; cpu_read = 1'b0;
      #1;
      check("reset_mid_fill", {bus_if.bus_request, bus_if.bus_read, array_write_data}, 32'd0);
      @(negedge clock);
      reset = 1'b0; bus_if.bus_grant = 1'b0; bus_q.delete();
      #1;
      check("after_reset_request", bus_if.bus_request, 32'd0);
      check("partial_words", {data_mem[6][0], data_mem[6][1]}, 32'h00C000C1);
      check("partial_state", state_mem[6], 32'h0);
      @(negedge clock);

      // Fresh read restarts the refill at word 0
      push_line(OP_RD, 8'h77, 4'd6, 16'h00D0);
      cpl_q.push_back('{is_read: 1'b1, data: 16'h00D3});
      run_req(1'b1, 1'b0, mk(8'h77, 4'd6, 2'd3), 16'h0000, 0, 6, 1);
      check("refill_state", state_mem[6], 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_cache_controller.md
Name: cpu_cache_controller

Overview:
- CPU-side controller for the direct-mapped snoopy cache line store; sits directly upstream of the storage array.
- Accepts processor read/write requests and drives the array's CPU port: index, offset, tag, state and data write strobes.
- On a miss or a write upgrade, it arbitrates for the shared bus, writes back a dirty victim and refills the line word by word.
- Uses the MSI protocol with state encoding INVALID=2'b00, SHARED=2'b01, MODIFIED=2'b10.

Parameters:
TAG_WIDTH, 8, tag field width
INDEX_WIDTH, 4, line index width (16 lines)
OFFSET_WIDTH, 2, word offset width (4 words/line)
DATA_WIDTH, 16, word width
ADDRESS_WIDTH, TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH, derived; address = {tag,index,offset}

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
cpu_address  in  ADDRESS_WIDTH  request address
cpu_read  in  1  read request, held until complete
cpu_write  in  1  write request, held until complete
cpu_data_in  in  DATA_WIDTH  write data
cpu_data_out  out  DATA_WIDTH  read data, valid when cpu_complete
cpu_complete  out  1  one-cycle completion pulse
array_index  out  INDEX_WIDTH  to array CPU index
array_offset  out  OFFSET_WIDTH  to array CPU offset
array_tag  out  TAG_WIDTH  tag to compare/write
array_tag_read  in  TAG_WIDTH  stored tag at array_index
array_state_read  in  2  stored state at array_index
array_hit  in  1  tag match and state != INVALID
array_data_read  in  DATA_WIDTH  stored word
array_write_tag  out  1  tag write strobe
array_write_state  out  1  state write strobe
array_state  out  2  state to write
array_write_data  out  1  data write strobe
array_data  out  DATA_WIDTH  data to write
bus_request  out  1  bus arbitration request
bus_grant  in  1  bus granted
bus_address  out  ADDRESS_WIDTH  transaction word address
bus_read  out  1  BusRd word read
bus_read_exclusive  out  1  BusRdX word read (write miss)
bus_invalidate  out  1  BusUpgr
bus_writeback  out  1  word writeback
bus_data_out  out  DATA_WIDTH  writeback data
bus_data_in  in  DATA_WIDTH  fill data
bus_ack  in  1  per-word/upgrade acknowledge

Behaviour:
- Reset: FSM to IDLE and word counter to 0. All strobes, bus_* controls and cpu_complete are 0; data outputs are 0.
- Reset has priority in every state. It aborts any transfer and drops bus_request in the next cycle. Array contents are untouched.
- array_index and array_tag come from cpu_address in IDLE and from the latched request in every other state.
- array_offset carries the CPU offset in IDLE and the word counter during WRITEBACK/FILL.
- States: IDLE, ARBITRATE, UPGRADE, WRITEBACK, FILL.
- IDLE, read with array_hit: cpu_complete=1 combinationally in the same cycle; cpu_data_out=array_data_read. Zero wait states.
- IDLE, write with array_hit and state MODIFIED: array_write_data=1 and cpu_complete=1 in the same cycle.
- IDLE, write with array_hit and state SHARED: latch the request and go to ARBITRATE; the upgrade is pending.
- IDLE, miss: latch the request and go to ARBITRATE.
- cpu_read and cpu_write both high: read takes priority.
- ARBITRATE: assert bus_request and wait for bus_grant. bus_request stays high until the cycle after the last ack of the transaction.
- On grant, next state is chosen in this order:
  - upgrade pending -> UPGRADE
  - victim state MODIFIED -> WRITEBACK
  - otherwise -> FILL
- UPGRADE: hold bus_invalidate and bus_address until bus_ack. On ack, write state MODIFIED and go to IDLE, where the write now hits.
- WRITEBACK:
  - bus_address = {array_tag_read, index, counter}.
  - Drive bus_writeback with bus_data_out=array_data_read.
  - Each bus_ack increments the counter.
  - After the ack on word 2^OFFSET_WIDTH-1, the counter wraps to 0 and the FSM goes to FILL without releasing the bus.
- FILL:
  - bus_address = {request tag, index, counter}.
  - Drive bus_read for a read miss, bus_read_exclusive for a write miss.
  - Each bus_ack asserts array_write_data with array_data=bus_data_in.
  - On the last word, also write the tag and write state: SHARED for a read, MODIFIED for a write. Counter wraps to 0, then back to IDLE.
- Re-entering IDLE re-evaluates the held request and it hits. Miss latency = arbitration + N acks (+N writeback acks) + 1 cycle.
- The CPU must hold its request stable until cpu_complete. If the request is withdrawn mid-transfer, the line transfer still finishes and no completion is issued.
- Snoop invalidation of the latched line during UPGRADE is the snoop controller's concern. The controller re-evaluates the hit in IDLE; a lost line then causes a normal miss.
- bus_ack while not in a bus state is ignored.

Test Plan:
- Read hit: preload line idx 3 tag 0x12 SHARED, word1=0xBEEF; read 0x12_3_1 -> cpu_complete same cycle, data 0xBEEF, no bus_request.
- Read miss, clean victim: idx 5 INVALID; read tag 0x40 -> 4 bus_read at offsets 0..3; bus data 0xA0..0xA3 written; tag 0x40 SHARED; completion with 0xA2 for offset 2.
- Dirty eviction: idx 5 tag 0x40 MODIFIED; write tag 0x41 -> 4 bus_writeback on {0x40,5,0..3} then 4 bus_read_exclusive; final state MODIFIED with the CPU word written; bus_request continuous.
- Upgrade: idx 2 SHARED hit, write 0x5555 -> one bus_invalidate; after ack state MODIFIED, word=0x5555, one completion.
- Grant delay and reset mid-fill: grant after 7 cycles, reset after 2nd ack -> next cycle bus_request=0, FSM IDLE, counter 0; a fresh read refills from word 0.
